// File: rtl/player_action_if.sv
// Bundle between the controller stage and the player action stage: per-frame
// strobe and debounced buttons in, player state/position/combat flags out.
interface player_action_if #(
  parameter int X_W = 10,
  parameter int Y_W = 9
);
  logic           frame_tick;
  logic [6:0]     controller_inputs;
  logic [2:0]     state;
  logic [X_W-1:0] pos_x;
  logic [Y_W-1:0] pos_y;
  logic           facing;
  logic           attack_active;
  logic           shield_active;

  modport master (
    output frame_tick, controller_inputs,
    input  state, pos_x, pos_y, facing, attack_active, shield_active
  );

  modport slave (
    input  frame_tick, controller_inputs,
    output state, pos_x, pos_y, facing, attack_active, shield_active
  );
endinterface

// File: rtl/player_action_fsm.sv
// Per-player action FSM stepped once per frame_tick: walk, jump, crouch, attack, shield.
// Optional `AIR_ATTACK_EN adds an attack sequence that runs alongside JUMP.
module player_action_fsm #(
  parameter int X_W         = 10,
  parameter int Y_W         = 9,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 575,
  parameter int X_INIT      = 100,
  parameter int WALK_SPEED  = 2,
  parameter int JUMP_VEL    = 12,
  parameter int GRAVITY     = 1,
  parameter int ATK_STARTUP = 3,
  parameter int ATK_ACTIVE  = 4,
  parameter int ATK_RECOVER = 6,
  parameter int FACE_INIT   = 1
) (
  input logic           clk,
  input logic           rst_n,
  player_action_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WALK        = 3'd1,
    ST_JUMP        = 3'd2,
    ST_CROUCH      = 3'd3,
    ST_ATK_STARTUP = 3'd4,
    ST_ATK_ACTIVE  = 3'd5,
    ST_ATK_RECOVER = 3'd6,
    ST_SHIELD      = 3'd7
  } state_t;

  localparam int CNT_MAX_SA = (ATK_STARTUP > ATK_ACTIVE) ? ATK_STARTUP : ATK_ACTIVE;
  localparam int CNT_MAX    = (CNT_MAX_SA > ATK_RECOVER) ? CNT_MAX_SA : ATK_RECOVER;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  typedef logic [CNT_W-1:0] cnt_t;

  localparam logic [X_W:0]        X_MIN_E  = (X_W+1)'(X_MIN);
  localparam logic [X_W:0]        X_MAX_E  = (X_W+1)'(X_MAX);
  localparam logic [X_W:0]        STEP_E   = (X_W+1)'(WALK_SPEED);
  localparam logic signed [Y_W:0] VEL_JUMP = (Y_W+1)'(JUMP_VEL);
  localparam logic signed [Y_W:0] VEL_GRAV = (Y_W+1)'(GRAVITY);

  state_t                state_q, state_d;
  logic [X_W-1:0]        pos_x_q, pos_x_d;
  logic [Y_W-1:0]        pos_y_q, pos_y_d;
  logic signed [Y_W:0]   vel_q, vel_d;
  cnt_t                  cnt_q, cnt_d;
  logic                  facing_q, facing_d;
  logic                  atk_prev_q, atk_prev_d;
  logic                  atk_act_q, shield_act_q;
  logic                  air_active_d;

  // An invalid controller frame behaves exactly like no buttons pressed.
  logic [5:0] btn;
  assign btn = bus.controller_inputs[6] ? bus.controller_inputs[5:0] : 6'b0;

  logic left, right, up, down, attack, shield, dir_l, dir_r, atk_edge;
  assign left     = btn[0];
  assign right    = btn[1];
  assign up       = btn[2];
  assign down     = btn[3];
  assign attack   = btn[4];
  assign shield   = btn[5];
  assign dir_l    = left & ~right;
  assign dir_r    = right & ~left;
  assign atk_edge = attack & ~atk_prev_q;

  // Horizontal step with saturation; one extra bit keeps the edge tests wrap-free.
  logic [X_W:0]   x_ext, x_inc;
  logic [X_W-1:0] moved_x;
  assign x_ext = {1'b0, pos_x_q};
  assign x_inc = x_ext + STEP_E;
  always_comb begin
    moved_x = pos_x_q;
    if (dir_r)
      moved_x = (x_inc > X_MAX_E) ? X_MAX_E[X_W-1:0] : x_inc[X_W-1:0];
    else if (dir_l)
      moved_x = (x_ext < X_MIN_E + STEP_E) ? X_MIN_E[X_W-1:0] : pos_x_q - STEP_E[X_W-1:0];
  end

  logic signed [Y_W+1:0] y_sum;
  logic                  landing;
  assign y_sum   = $signed({2'b00, pos_y_q}) + $signed({vel_q[Y_W], vel_q});
  assign landing = y_sum[Y_W+1] | (y_sum == '0);

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    vel_d      = vel_q;
    cnt_d      = cnt_q;
    facing_d   = facing_q;
    atk_prev_d = atk_prev_q;
    if (bus.frame_tick) begin
      atk_prev_d = attack;
      if ((state_q == ST_IDLE || state_q == ST_WALK || state_q == ST_JUMP) && (dir_l || dir_r))
        facing_d = dir_r;
      case (state_q)
        ST_IDLE, ST_WALK, ST_CROUCH: begin
          if (atk_edge) begin
            state_d = ST_ATK_STARTUP;
            cnt_d   = cnt_t'(ATK_STARTUP - 1);
          end else if (shield) begin
            state_d = ST_SHIELD;
          end else if (up) begin
            state_d = ST_JUMP;
            vel_d   = VEL_JUMP;
          end else if (down) begin
            state_d = ST_CROUCH;
          end else if (dir_l || dir_r) begin
            state_d = ST_WALK;
            pos_x_d = moved_x;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_JUMP: begin
          pos_x_d = moved_x;
          if (landing) begin
            pos_y_d = '0;
            vel_d   = '0;
            state_d = ST_IDLE;
          end else begin
            pos_y_d = y_sum[Y_W-1:0];
            vel_d   = vel_q - VEL_GRAV;
          end
        end
        ST_ATK_STARTUP: begin
          if (cnt_q == '0) begin
            state_d = ST_ATK_ACTIVE;
            cnt_d   = cnt_t'(ATK_ACTIVE - 1);
          end else cnt_d = cnt_q - cnt_t'(1);
        end
        ST_ATK_ACTIVE: begin
          if (cnt_q == '0) begin
            state_d = ST_ATK_RECOVER;
            cnt_d   = cnt_t'(ATK_RECOVER - 1);
          end else cnt_d = cnt_q - cnt_t'(1);
        end
        ST_ATK_RECOVER: begin
          if (cnt_q == '0) state_d = ST_IDLE;
          else             cnt_d   = cnt_q - cnt_t'(1);
        end
        ST_SHIELD: if (!shield) state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

`ifdef AIR_ATTACK_EN
  typedef enum logic [1:0] {AIR_NONE, AIR_STARTUP, AIR_ACTIVE} air_t;
  air_t air_q, air_d;
  cnt_t air_cnt_q, air_cnt_d;

  // The startup count is loaded with ATK_STARTUP (not -1) so the edge tick itself is not a startup frame.
  always_comb begin
    air_d     = air_q;
    air_cnt_d = air_cnt_q;
    if (bus.frame_tick && state_q == ST_JUMP) begin
      if (landing) air_d = AIR_NONE;
      else begin
        case (air_q)
          AIR_NONE: if (atk_edge) begin
            air_d     = AIR_STARTUP;
            air_cnt_d = cnt_t'(ATK_STARTUP);
          end
          AIR_STARTUP: if (air_cnt_q == '0) begin
            air_d     = AIR_ACTIVE;
            air_cnt_d = cnt_t'(ATK_ACTIVE - 1);
          end else air_cnt_d = air_cnt_q - cnt_t'(1);
          AIR_ACTIVE: if (air_cnt_q == '0) air_d = AIR_NONE;
                      else air_cnt_d = air_cnt_q - cnt_t'(1);
          default: air_d = AIR_NONE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      air_q     <= AIR_NONE;
      air_cnt_q <= '0;
    end else begin
      air_q     <= air_d;
      air_cnt_q <= air_cnt_d;
    end
  end

  assign air_active_d = (air_d == AIR_ACTIVE);
`else
  assign air_active_d = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pos_x_q      <= X_W'(X_INIT);
      pos_y_q      <= '0;
      vel_q        <= '0;
      cnt_q        <= '0;
      facing_q     <= 1'(FACE_INIT);
      atk_prev_q   <= 1'b0;
      atk_act_q    <= 1'b0;
      shield_act_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      vel_q        <= vel_d;
      cnt_q        <= cnt_d;
      facing_q     <= facing_d;
      atk_prev_q   <= atk_prev_d;
      atk_act_q    <= (state_d == ST_ATK_ACTIVE) | air_active_d;
      shield_act_q <= (state_d == ST_SHIELD);
    end
  end

  assign bus.state         = state_q;
  assign bus.pos_x         = pos_x_q;
  assign bus.pos_y         = pos_y_q;
  assign bus.facing        = facing_q;
  assign bus.attack_active = atk_act_q;
  assign bus.shield_active = shield_act_q;

endmodule

// File: tb/tb_player_action_fsm.sv
// Scoreboard bench for player_action_fsm: stimulus pushes hand-computed per-tick
// expectations, an independent monitor pops and compares after every frame step.
module tb_player_action_fsm;

  localparam logic [6:0] N = 7'h40, L = 7'h41, R = 7'h42, LR = 7'h43, U = 7'h44,
                         D = 7'h48, DR = 7'h4a, A = 7'h50, AL = 7'h51, AR = 7'h52,
                         S = 7'h60, SAL = 7'h71;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_WALK = 3'd1, ST_JUMP = 3'd2, ST_CROUCH = 3'd3,
                         ST_STARTUP = 3'd4, ST_ACTIVE = 3'd5, ST_RECOVER = 3'd6,
                         ST_SHIELD = 3'd7;
`ifdef AIR_ATTACK_EN
  localparam bit AIR = 1'b1;
`else
  localparam bit AIR = 1'b0;
`endif

  typedef struct {
    int         id;
    logic [2:0] st;
    logic [9:0] x;
    logic [8:0] y;
    logic       f;
    logic       aa;
    logic       sa;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic tick_seen = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   next_id = 0;
  exp_t sb[$];

  player_action_if #(.X_W(10), .Y_W(9)) bus ();

  player_action_fsm dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tick_seen <= bus.frame_tick;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, actual, expected);
    end
  endtask

  task automatic pop_compare(input string src);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got output with no expectation queued", src);
    end else begin
      e = sb.pop_front();
      check($sformatf("v%0d state", e.id),  32'(bus.state),         32'(e.st));
      check($sformatf("v%0d pos_x", e.id),  32'(bus.pos_x),         32'(e.x));
      check($sformatf("v%0d pos_y", e.id),  32'(bus.pos_y),         32'(e.y));
      check($sformatf("v%0d facing", e.id), 32'(bus.facing),        32'(e.f));
      check($sformatf("v%0d atk", e.id),    32'(bus.attack_active), 32'(e.aa));
      check($sformatf("v%0d shield", e.id), 32'(bus.shield_active), 32'(e.sa));
    end
  endtask

  // Monitor: one pop per frame step, plus one pop per asynchronous reset assertion.
  initial begin
    fork
      forever begin
        @(negedge clk);
        if (tick_seen) pop_compare("tick");
      end
      forever begin
        @(negedge rst_n);
        #1;
        pop_compare("reset");
      end
    join
  end

  function automatic exp_t ex(input logic [2:0] st, input int x, input int y,
                              input logic f, input logic aa, input logic sa);
    exp_t e;
    e.id = next_id;
    e.st = st;
    e.x  = 10'(x);
    e.y  = 9'(y);
    e.f  = f;
    e.aa = aa;
    e.sa = sa;
    next_id++;
    return e;
  endfunction

  // Called at a falling edge; optional idle gap checks that nothing moves without a tick.
  task automatic tick(input logic [6:0] ci, input exp_t e, input bit gap = 1'b1);
    sb.push_back(e);
    bus.controller_inputs = ci;
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    if (gap) @(negedge clk);
  endtask

  task automatic reset_now(input exp_t e);
    sb.push_back(e);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int jump_y(input int k);
    return (k >= 25) ? 0 : 12 * k - (k * (k - 1)) / 2;
  endfunction

  function automatic logic [2:0] atk_state(input int k);
    if (k <= 3)  return ST_STARTUP;
    if (k <= 7)  return ST_ACTIVE;
    if (k <= 13) return ST_RECOVER;
    return ST_IDLE;
  endfunction

  initial begin
    bus.frame_tick = 1'b0;
    bus.controller_inputs = N;
    #2;
    reset_now(ex(ST_IDLE, 100, 0, 1, 0, 0));

    // Walk right, then both directions cancel.
    for (int k = 1; k <= 10; k++) tick(R, ex(ST_WALK, 100 + 2 * k, 0, 1, 0, 0));
    for (int k = 1; k <= 5; k++)  tick(LR, ex(ST_IDLE, 120, 0, 1, 0, 0));
    tick(L, ex(ST_WALK, 118, 0, 0, 0, 0));

    // Right edge saturation at 575, then left edge clamp through 1 -> 0.
    for (int k = 1; k <= 231; k++)
      tick(R, ex(ST_WALK, (118 + 2 * k > 575) ? 575 : 118 + 2 * k, 0, 1, 0, 0));
    for (int k = 1; k <= 289; k++)
      tick(L, ex(ST_WALK, (575 - 2 * k < 0) ? 0 : 575 - 2 * k, 0, 0, 0, 0));
    tick(N, ex(ST_IDLE, 0, 0, 0, 0, 0));

    // Jump with an attack press on jump tick 2.
    tick(U, ex(ST_JUMP, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 25; k++)
      tick((k == 2) ? A : N, ex((k == 25) ? ST_IDLE : ST_JUMP, 0, jump_y(k), 0,
                                AIR && k >= 6 && k <= 9, 0));

    // Jump drifting right; air attack started at tick 20 is cut by landing at 25.
    tick(U, ex(ST_JUMP, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 25; k++)
      tick((k == 20) ? AR : R, ex((k == 25) ? ST_IDLE : ST_JUMP, 2 * k, jump_y(k), 1,
                                  AIR && k == 24, 0));

    // Ground attack held 20 ticks: one sequence only, no motion while attacking.
    tick(N, ex(ST_IDLE, 50, 0, 1, 0, 0));
    for (int k = 1; k <= 20; k++)
      tick((k == 1 || k > 13) ? A : AL,
           ex(atk_state(k), 50, 0, 1, k >= 4 && k <= 7, 0));
    tick(N, ex(ST_IDLE, 50, 0, 1, 0, 0));
    for (int k = 1; k <= 14; k++)
      tick((k == 1) ? A : N, ex(atk_state(k), 50, 0, 1, k >= 4 && k <= 7, 0));

    // Shield held 5 ticks with an ignored attack edge; release tick goes to IDLE.
    for (int k = 1; k <= 5; k++)
      tick((k == 3) ? SAL : S, ex(ST_SHIELD, 50, 0, 1, 0, 1));
    tick(D, ex(ST_IDLE, 50, 0, 1, 0, 0));
    tick(D, ex(ST_CROUCH, 50, 0, 1, 0, 0));
    tick(DR, ex(ST_CROUCH, 50, 0, 1, 0, 0));
    tick(N, ex(ST_IDLE, 50, 0, 1, 0, 0));
    tick(L, ex(ST_WALK, 48, 0, 0, 0, 0));

    // Controller valid low masks every button.
    for (int k = 1; k <= 3; k++) tick(7'h02, ex(ST_IDLE, 48, 0, 0, 0, 0));
    tick(7'h3f, ex(ST_IDLE, 48, 0, 0, 0, 0));

    // Back-to-back ticks each count as a full frame.
    for (int k = 1; k <= 4; k++) tick(R, ex(ST_WALK, 48 + 2 * k, 0, 1, 0, 0), 1'b0);
    tick(N, ex(ST_IDLE, 56, 0, 1, 0, 0));

    // Asynchronous reset between clock edges in mid-jump.
    tick(U, ex(ST_JUMP, 56, 0, 1, 0, 0));
    for (int k = 1; k <= 3; k++) tick(N, ex(ST_JUMP, 56, jump_y(k), 1, 0, 0));
    bus.controller_inputs = L;
    #2;
    reset_now(ex(ST_IDLE, 100, 0, 1, 0, 0));
    tick(N, ex(ST_IDLE, 100, 0, 1, 0, 0));
    tick(R, ex(ST_WALK, 102, 0, 1, 0, 0));

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d expectations left want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/player_action_fsm.md
Name: player_action_fsm

Overview:
- Per-player action stage directly downstream of the controller block.
- Consumes the 7-bit debounced controller input vector and produces player state, position and combat flags.
- Outputs are read by the renderer and the hit/collision logic.
- Advances only on a one-cycle frame_tick pulse (one pulse per video frame), so gameplay timing is counted in frames rather than clock cycles.

Parameters:
X_W, 10, width of horizontal position
Y_W, 9, width of vertical height above ground
X_MIN, 0, left position limit
X_MAX, 575, right position limit
X_INIT, 100, position after reset
WALK_SPEED, 2, pixels per frame while walking or airborne
JUMP_VEL, 12, initial upward velocity (pixels/frame)
GRAVITY, 1, velocity decrement per frame
ATK_STARTUP, 3, attack startup frames
ATK_ACTIVE, 4, attack active frames
ATK_RECOVER, 6, attack recovery frames
FACE_INIT, 1, facing after reset (1 = right)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
frame_tick  input  1  one-clk pulse per frame; all state updates occur only on this cycle
controller_inputs  input  7  [0] left, [1] right, [2] up, [3] down, [4] attack, [5] shield, [6] controller valid; all active-high
state  output  3  0 IDLE, 1 WALK, 2 JUMP, 3 CROUCH, 4 ATK_STARTUP, 5 ATK_ACTIVE, 6 ATK_RECOVER, 7 SHIELD
pos_x  output  X_W  horizontal position, unsigned
pos_y  output  Y_W  height above ground, unsigned; 0 means grounded
facing  output  1  1 = right, 0 = left
attack_active  output  1  hitbox live
shield_active  output  1  blocking

Behaviour:
- Reset (async, rst_n low):
  - state IDLE, pos_x X_INIT, pos_y 0, facing FACE_INIT.
  - attack_active 0, shield_active 0.
  - Internal velocity, frame counter and previous-attack register cleared.
  - Reset asserted mid-jump or mid-attack aborts immediately.
- Outputs are registered and change only on the clk edge where frame_tick = 1. Latency is 1 clk from the tick.
- If controller_inputs[6] = 0, bits [5:0] are treated as all 0.
- Attack trigger is edge-based: atk_edge = attack & ~attack_prev. attack_prev is updated on every tick only.
- Direction:
  - dir_l = left & ~right; dir_r = right & ~left.
  - Both pressed gives no motion.
  - facing updates on a tick whenever dir_l or dir_r is set, in IDLE, WALK or JUMP only.
- Grounded decision (IDLE, WALK, CROUCH), one priority per tick:
  - atk_edge: ATK_STARTUP, counter = ATK_STARTUP-1.
  - shield: SHIELD.
  - up: JUMP, vel = JUMP_VEL.
  - down: CROUCH.
  - dir_l or dir_r: WALK.
  - otherwise IDLE.
- WALK: pos_x += ±WALK_SPEED on the same tick, saturating at X_MIN/X_MAX. No wrap. Subtraction below X_MIN clamps to X_MIN.
- JUMP:
  - Each tick: if pos_y + vel <= 0 (signed), pos_y = 0 and go to IDLE. Otherwise pos_y += vel, then vel -= GRAVITY.
  - Horizontal motion as in WALK. Attack, shield and down are ignored.
  - vel is signed, Y_W+1 bits.
- CROUCH: no motion. Leaves via the grounded priority when down is released.
- Attack sequence:
  - Counter decrements each tick.
  - When counter = 0, advance STARTUP → ACTIVE (counter = ATK_ACTIVE-1) → RECOVER (counter = ATK_RECOVER-1) → IDLE.
  - Inputs ignored, no motion. Total ATK_STARTUP+ATK_ACTIVE+ATK_RECOVER ticks.
- SHIELD: held while shield = 1. Release returns to IDLE on that tick; grounded priority is evaluated on the next tick.
- attack_active = (state == ATK_ACTIVE); shield_active = (state == SHIELD). Both are registered with state.
- frame_tick asserted on consecutive clocks: each pulse is a full frame step.

Optional Feature:
- AIR_ATTACK_EN:
  - Defined: atk_edge during JUMP starts an air attack with its own counter. attack_active is high for ATK_ACTIVE ticks starting the tick after ATK_STARTUP ticks. state stays JUMP and physics continue.
  - Landing cancels the air attack: attack_active = 0 and no recovery.
  - Undefined: attack ignored in JUMP; no air-attack counter logic synthesized.

Test Plan:
- Reset, then right held for 10 ticks → state WALK, pos_x 120, facing 1. Left+right together for 5 ticks → IDLE, pos_x 120.
- pos_x 574, right held 3 ticks → pos_x 575 and stays 575. Reset to X_INIT, drive to 1, left held → pos_x 0, no wrap.
- up pulse on one tick → JUMP; pos_y 12, 23, 33 on ticks 1–3; peak 78 after tick 12; pos_y 0 and IDLE after tick 25.
- attack held high for 20 ticks → one sequence only: attack_active high exactly ticks 4–7, IDLE after tick 13. A second press needs release and re-press.
- shield held 5 ticks, then released → shield_active high 5 ticks. Attack edge during shield ignored. IDLE on the release tick.
- rst_n low mid-jump between clock edges → outputs return to reset values immediately. controller_inputs[6]=0 with right=1 → no motion.
- AIR_ATTACK_EN defined: attack at jump tick 2 → attack_active high ticks 6–9, landing at tick 25. Without AIR_ATTACK_EN: attack_active stays 0.
